// File: rtl/guess_pkg.sv
`default_nettype none
// ============================================================================
// Module   : guess_pkg
// Purpose  : Shared constants and types for the guessing-game scoreboard:
//            seven-segment encodings (active-low {g,f,e,d,c,b,a}), anode
//            idle pattern, BCD digit type and a digit decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package guess_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Index n holds the active-low segment pattern for decimal digit n.
    localparam logic [6:0] SEG_DIGITS [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // Non-decimal codes 10..15 should never appear; show them as blank.
    function automatic logic [6:0] seg_decode(input bcd_digit_t digit);
        if (digit < 4'd10) begin
            return SEG_DIGITS[digit];
        end
        return SEG_BLANK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd2_counter
// Purpose  : Two-digit BCD event counter, 00..99, saturating at 99.
//            A clear has priority over a same-cycle increment.
// Ports    : clk   - clock
//            reset - synchronous active-low reset
//            inc   - count one event this cycle
//            clr   - clear to 00 (wins over inc)
//            tens  - tens digit
//            ones  - ones digit
// Revision : 1.0 - initial release
// ============================================================================
module bcd2_counter
    import guess_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output bcd_digit_t tens,
    output bcd_digit_t ones
);

    bcd_digit_t r_tens;
    bcd_digit_t r_ones;

    logic w_at_max;
    assign w_at_max = (r_tens == 4'd9) && (r_ones == 4'd9);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (clr) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (inc && !w_at_max) begin
            if (r_ones == 4'd9) begin
                r_ones <= 4'd0;
                r_tens <= r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

    assign tens = r_tens;
    assign ones = r_ones;

endmodule
`default_nettype wire

// File: rtl/guess_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : guess_scoreboard
// Purpose  : Counts rising edges of the game FSM win/lose levels in two BCD
//            counters and multiplexes them onto a four-digit seven-segment
//            display (wins left, losses right, leading-zero tens blanked).
// Ports    : clk   - board clock
//            reset - synchronous active-low reset
//            win   - game win level
//            lose  - game lose level
//            clr   - clear both counters (level, active-high)
//            seg   - segment cathodes {g..a}, active-low, registered
//            an    - digit anodes, active-low one-hot, registered
// Revision : 1.0 - initial release
// ============================================================================
module guess_scoreboard
    import guess_pkg::*;
#(
    parameter int REFRESH_N = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       win,
    input  logic       lose,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [REFRESH_N-1:0] c_scan_one = REFRESH_N'(1);

    logic                 r_win_q;
    logic                 r_lose_q;
    logic [REFRESH_N-1:0] r_scan;
    logic [6:0]           r_seg;
    logic [3:0]           r_an;

    logic       w_win_evt;
    logic       w_lose_evt;
    logic [1:0] w_d;
    bcd_digit_t w_win_tens, w_win_ones, w_loss_tens, w_loss_ones;
    bcd_digit_t w_digit;
    logic       w_is_tens;
    logic [3:0] w_an_next;
    logic [6:0] w_seg_next;

    // Previous-level registers idle high so a level already asserted when
    // reset releases does not look like a fresh edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_win_q  <= 1'b1;
            r_lose_q <= 1'b1;
        end else begin
            r_win_q  <= win;
            r_lose_q <= lose;
        end
    end

    assign w_win_evt  = win  & ~r_win_q;
    assign w_lose_evt = lose & ~r_lose_q;

    bcd2_counter u_wins (
        .clk   (clk),
        .reset (reset),
        .inc   (w_win_evt),
        .clr   (clr),
        .tens  (w_win_tens),
        .ones  (w_win_ones)
    );

    bcd2_counter u_losses (
        .clk   (clk),
        .reset (reset),
        .inc   (w_lose_evt),
        .clr   (clr),
        .tens  (w_loss_tens),
        .ones  (w_loss_ones)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + c_scan_one;
        end
    end

    assign w_d = r_scan[REFRESH_N-1 -: 2];

    always_comb begin
        w_digit   = w_loss_ones;
        w_is_tens = 1'b0;
        w_an_next = 4'b1110;
        case (w_d)
            2'd0: begin
                w_digit   = w_loss_ones;
                w_is_tens = 1'b0;
                w_an_next = 4'b1110;
            end
            2'd1: begin
                w_digit   = w_loss_tens;
                w_is_tens = 1'b1;
                w_an_next = 4'b1101;
            end
            2'd2: begin
                w_digit   = w_win_ones;
                w_is_tens = 1'b0;
                w_an_next = 4'b1011;
            end
            default: begin
                w_digit   = w_win_tens;
                w_is_tens = 1'b1;
                w_an_next = 4'b0111;
            end
        endcase
    end

    // Leading zero suppression: the anode still fires, the segments stay dark.
    assign w_seg_next = (w_is_tens && (w_digit == 4'd0)) ? SEG_BLANK
                                                          : seg_decode(w_digit);

    // Anode and segment share one register stage so they switch together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_an  <= ANODE_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule
`default_nettype wire
